// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between fetch and load/store; data wins unless fetch has starved STARVE_LIMIT grants
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  arb_owner
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t state, state_n;
    logic [3:0] starve_cnt;
    logic grant_if, grant_d, done;
    always_comb begin
        done = (state == BUSY_IF || state == BUSY_D) && mem_ready;
        grant_d = state == IDLE && d_req && !(if_req && starve_cnt == LIMIT);
        grant_if = state == IDLE && if_req && !grant_d;
        state_n = grant_d ? BUSY_D : grant_if ? BUSY_IF : done ? RESP : state == RESP ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            starve_cnt <= 4'd0;
            if_rdata <= 32'd0;
            if_ready <= 1'b0;
            d_rdata <= 32'd0;
            d_ready <= 1'b0;
            mem_valid <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
            arb_owner <= 2'b00;
        end else begin
            state <= state_n;
            if_ready <= done && state == BUSY_IF;
            d_ready <= done && state == BUSY_D;
            if (grant_if) begin
                mem_valid <= 1'b1;
                mem_we <= 1'b0;
                mem_addr <= if_addr;
                mem_wdata <= 32'd0;
                mem_wstrb <= 4'd0;
                arb_owner <= 2'b01;
                starve_cnt <= 4'd0;
            end else if (grant_d) begin
                mem_valid <= 1'b1;
                mem_we <= d_we;
                mem_addr <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_we ? d_wstrb : 4'd0;
                arb_owner <= 2'b10;
                starve_cnt <= (if_req && starve_cnt < LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
            end
            if (done) begin
                mem_valid <= 1'b0;
                if (state == BUSY_IF) if_rdata <= mem_rdata;
                else if (!mem_we) d_rdata <= mem_rdata;
            end
            if (state == RESP) arb_owner <= 2'b00;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and scoreboarded checks of mem_arbiter against a wait-state memory model
module tb_mem_arbiter;
    logic clk = 0, rst_n = 0;
    logic if_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0] d_wstrb = 0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic if_ready, d_ready, mem_valid, mem_we;
    logic [3:0] mem_wstrb;
    logic [1:0] arb_owner;
    int checks = 0, errors = 0, wait_cfg = 0, vcnt = 0;

    typedef struct {
        logic [1:0] owner;
        logic we;
        logic [31:0] addr, wdata;
        logic [3:0] wstrb;
        logic [31:0] rdata;
        int waits;
    } exp_t;
    typedef struct {
        logic d, we;
        logic [31:0] addr, wdata;
        logic [3:0] wstrb;
        int waits, lat;
        logic [3:0] exp_wstrb;
    } vec_t;
    exp_t q[$];
    vec_t vt[6];

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_owner(arb_owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdl(input logic [31:0] a);
        return a == 32'h100 ? 32'h13 : a == 32'h3000 ? 32'h55 : {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1111;
    endfunction

    function automatic exp_t mk(input logic d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int waits);
        exp_t e;
        e.owner = d ? 2'b10 : 2'b01;
        e.we = d & we;
        e.addr = addr;
        e.wdata = d ? wdata : 32'h0;
        e.wstrb = (d & we) ? wstrb : 4'h0;
        e.rdata = mdl(addr);
        e.waits = waits;
        return e;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_bus", {mem_valid, mem_we, mem_addr, mem_wstrb, arb_owner}, 0);
        chk("rst_wdata_ready", {mem_wdata, if_ready, d_ready}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
    endtask

    // Memory responder: completes after wait_cfg extra cycles of mem_valid
    always @(negedge clk) begin
        mem_ready = mem_valid && vcnt == wait_cfg;
        mem_rdata = mem_ready ? mdl(mem_addr) : 32'hBAD0_BAD0;
        vcnt = mem_valid ? vcnt + 1 : 0;
    end

    logic pv = 0, gwe;
    logic [1:0] gown;
    logic [31:0] gaddr, gwdata, exp_if = 0, exp_d = 0;
    logic [3:0] gwstrb;
    int vcyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_if = 0;
            exp_d = 0;
        end
        if (mem_valid && !pv) begin
            vcyc = 1;
            gown = arb_owner;
            gwe = mem_we;
            gaddr = mem_addr;
            gwdata = mem_wdata;
            gwstrb = mem_wstrb;
        end else if (mem_valid) begin
            vcyc++;
            chk("mem_stable", {arb_owner, mem_we, mem_addr, mem_wdata, mem_wstrb}, {gown, gwe, gaddr, gwdata, gwstrb});
        end
        if (if_ready || d_ready) begin
            if (q.size() == 0) chk("spurious_ready", {d_ready, if_ready}, 0);
            else begin
                e = q.pop_front();
                chk("ready_which", {d_ready, if_ready}, e.owner);
                chk("owner_at_grant", gown, e.owner);
                chk("owner_at_ready", arb_owner, e.owner);
                chk("mem_we", gwe, e.we);
                chk("mem_addr", gaddr, e.addr);
                chk("mem_wdata", gwdata, e.wdata);
                chk("mem_wstrb", gwstrb, e.wstrb);
                chk("valid_cycles", vcyc, e.waits + 1);
                chk("valid_dropped", mem_valid, 0);
                if (e.owner == 2'b01) exp_if = e.rdata;
                else if (!e.we) exp_d = e.rdata;
                chk("if_rdata", if_rdata, exp_if);
                chk("d_rdata", d_rdata, exp_d);
            end
        end
        pv = mem_valid;
    end

    task automatic run_vec(input vec_t v);
        int lat;
        exp_t e;
        e = mk(v.d, v.we, v.addr, v.wdata, v.wstrb, v.waits);
        e.wstrb = v.exp_wstrb;
        @(posedge clk); #1;
        wait_cfg = v.waits;
        if (v.d) begin
            d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
        end else begin
            if_req = 1; if_addr = v.addr; d_we = 1; d_wdata = v.wdata; d_wstrb = v.wstrb; d_addr = 32'hFFFF_FFF0;
        end
        q.push_back(e);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(if_ready || d_ready) && lat < 50);
        if_req = 0;
        d_req = 0;
        chk("latency", lat, v.lat);
    endtask

    initial begin
        int n, last, t_d, t_i;
        vt = '{
            '{1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_0000, 4'hF,    0, 2, 4'h0},
            '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 3, 5, 4'b0011},
            '{1'b1, 1'b0, 32'h0000_2000, 32'h0000_1234, 4'hF,    1, 3, 4'h0},
            '{1'b0, 1'b0, 32'h0000_0104, 32'h1111_2222, 4'hA,    2, 4, 4'h0},
            '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b1100, 0, 2, 4'b1100},
            '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         4'h0,    0, 2, 4'h0}
        };
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset();
        rst_n = 1;
        foreach (vt[i]) run_vec(vt[i]);

        @(posedge clk); #1;
        wait_cfg = 0;
        d_req = 1; d_we = 0; d_addr = 32'h3000; d_wdata = 0; d_wstrb = 4'hF;
        if_req = 1; if_addr = 32'h100;
        q.push_back(mk(1, 0, 32'h3000, 0, 4'hF, 0));
        q.push_back(mk(0, 0, 32'h100, 0, 0, 0));
        t_d = -1; t_i = -1;
        for (int c = 1; c <= 40 && t_i < 0; c++) begin
            @(posedge clk); #1;
            if (d_ready) begin t_d = c; d_req = 0; end
            if (if_ready) begin t_i = c; if_req = 0; end
        end
        chk("sim_d_first", t_d, 2);
        chk("sim_gap", t_i - t_d, 3);

        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_addr = 32'h3000; if_req = 1; if_addr = 32'h500;
        for (int g = 0; g < 10; g++)
            q.push_back(g % 5 == 4 ? mk(0, 0, 32'h500, 0, 0, 0) : mk(1, 0, 32'h3000, 0, 4'hF, 0));
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(posedge clk); #1;
            if (if_ready || d_ready) begin
                n++;
                if (n == 10) begin if_req = 0; d_req = 0; end
            end
        end
        chk("starve_done", n, 10);

        @(posedge clk); #1;
        if_req = 1; if_addr = 0;
        for (int i = 0; i < 8; i++) q.push_back(mk(0, 0, 32'(4 * i), 0, 0, 0));
        n = 0; last = 0;
        for (int c = 1; c < 200 && n < 8; c++) begin
            @(posedge clk); #1;
            if (if_ready) begin
                if (n == 0) chk("b2b_first", c, 2);
                else chk("b2b_gap", c - last, 3);
                last = c;
                n++;
                if (n < 8) if_addr = 32'(4 * n);
                else if_req = 0;
            end
        end
        chk("b2b_count", n, 8);

        @(posedge clk); #1;
        wait_cfg = 1000; if_req = 1; if_addr = 32'h800;
        repeat (2) begin @(posedge clk); #1; end
        chk("pre_reset_valid", mem_valid, 1);
        rst_n = 0; if_req = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk_reset();
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (if_ready) n++;
        end
        chk("no_if_ready_after_reset", n, 0);
        run_vec('{1'b0, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 2, 4'h0});
        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end
endmodule
